// File: rtl/mem_arb_pkg.sv
// Shared types for the program/data memory arbiter: FSM states, CPUstate
// encodings and the owner encoding used by the round-robin picker.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_IN    = 2'b01;
   localparam logic [1:0] ST_CHECK = 2'b10;
   localparam logic [1:0] ST_RUN   = 2'b11;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_PNL = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-requester round-robin picker. It is kept generic so the
// I/O port arbiter can reuse it.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic   i_req_cpu,
   input  logic   i_req_pnl,
   input  owner_t i_last_owner,
   output logic   o_valid,
   output owner_t o_owner
);

   // On a tie the requester that was not served last wins.
   always_comb begin
      o_valid = i_req_cpu | i_req_pnl;
      o_owner = OWN_CPU;
      if (i_req_pnl && (!i_req_cpu || i_last_owner == OWN_CPU)) begin
         o_owner = OWN_PNL;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port memory between the CPU controller and the
// front-panel loader, with a fixed WAIT+1 cycle access phase.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW   = 16,
   parameter int DW   = 8,
   parameter int WAIT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    CPUstate,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   input  logic          pnl_req,
   input  logic          pnl_we,
   input  logic [AW-1:0] pnl_addr,
   input  logic [DW-1:0] pnl_wdata,
   output logic          pnl_gnt,
   output logic          pnl_done,
   output logic [DW-1:0] pnl_rdata,
   output logic          pnl_err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [2:0] WCNT_LAST = 3'(WAIT);

   state_t        r_state;
   owner_t        r_owner;
   owner_t        r_last_owner;
   logic          r_we;
   logic          r_reject;
   logic [2:0]    r_wcnt;

   logic          w_elig_cpu;
   logic          w_elig_pnl;
   logic          w_valid;
   owner_t        w_owner;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_reject;

   assign w_elig_cpu = cpu_req && (CPUstate == ST_RUN);
   assign w_elig_pnl = pnl_req && (CPUstate != ST_IDLE);

   arb_rr2 u_rr (
      .i_req_cpu    (w_elig_cpu),
      .i_req_pnl    (w_elig_pnl),
      .i_last_owner (r_last_owner),
      .o_valid      (w_valid),
      .o_owner      (w_owner)
   );

   assign w_we     = (w_owner == OWN_PNL) ? pnl_we    : cpu_we;
   assign w_addr   = (w_owner == OWN_PNL) ? pnl_addr  : cpu_addr;
   assign w_wdata  = (w_owner == OWN_PNL) ? pnl_wdata : cpu_wdata;
   // Panel writes in CHECK mode run the full access timing without a strobe.
   assign w_reject = (w_owner == OWN_PNL) && pnl_we && (CPUstate == ST_CHECK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_owner      <= OWN_CPU;
         r_last_owner <= OWN_PNL;
         r_we         <= 1'b0;
         r_reject     <= 1'b0;
         r_wcnt       <= 3'd0;
         cpu_gnt      <= 1'b0;
         pnl_gnt      <= 1'b0;
         cpu_done     <= 1'b0;
         pnl_done     <= 1'b0;
         pnl_err      <= 1'b0;
         cpu_rdata    <= '0;
         pnl_rdata    <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state   <= ACC;
                  r_owner   <= w_owner;
                  r_we      <= w_we;
                  r_reject  <= w_reject;
                  r_wcnt    <= 3'd0;
                  mem_addr  <= w_addr;
                  mem_wdata <= w_wdata;
                  mem_read  <= !w_we;
                  mem_write <= w_we && !w_reject;
                  cpu_gnt   <= (w_owner == OWN_CPU);
                  pnl_gnt   <= (w_owner == OWN_PNL);
                  busy      <= 1'b1;
               end
            end
            ACC: begin
               if (r_wcnt == WCNT_LAST) begin
                  r_state   <= RESP;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (!r_we) begin
                     if (r_owner == OWN_CPU) cpu_rdata <= mem_rdata;
                     else                    pnl_rdata <= mem_rdata;
                  end
                  cpu_done  <= (r_owner == OWN_CPU);
                  pnl_done  <= (r_owner == OWN_PNL);
                  pnl_err   <= r_reject;
               end else begin
                  r_wcnt <= r_wcnt + 3'd1;
               end
            end
            RESP: begin
               r_state      <= IDLE;
               r_last_owner <= r_owner;
               cpu_done     <= 1'b0;
               pnl_done     <= 1'b0;
               pnl_err      <= 1'b0;
               cpu_gnt      <= 1'b0;
               pnl_gnt      <= 1'b0;
               busy         <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
